// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues single-outstanding imem requests and buffers {pc, instr} for decode.
// Optional misaligned-redirect trap (HALT state, sticky fetch_fault) is enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2, ST_HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2} state_t;
`endif

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      pc_r;
    logic [31:0]      inflight_pc_r;
    logic [31:0]      target_pc_s;
    logic [31:0]      fifo_pc_r    [FIFO_DEPTH];
    logic [31:0]      fifo_instr_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             req_fire_s;
    logic             push_s;
    logic             pop_s;

    assign req_fire_s = imem_req_valid & imem_req_ready;
    // A response is only kept when it belongs to the current path.
    assign push_s     = (state_r == ST_WAIT) & imem_rsp_valid & ~redirect_valid;
    assign pop_s      = id_valid & id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_s;
    logic fault_r;
    logic halt_pend_r;

    assign misalign_s  = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign target_pc_s = redirect_pc;
    assign fetch_fault = fault_r;

    // Sticky fault flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (redirect_valid) begin
            fault_r <= misalign_s;
        end else begin
            fault_r <= fault_r;
        end
    end

    // Remembers a response still owed by memory when HALT is entered, so leaving HALT drains it first.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_pend_r <= 1'b0;
        end else if (misalign_s && (state_r != ST_HALT)) begin
            halt_pend_r <= req_fire_s |
                           (((state_r == ST_WAIT) | (state_r == ST_DRAIN)) & ~imem_rsp_valid);
        end else if (imem_rsp_valid) begin
            halt_pend_r <= 1'b0;
        end else begin
            halt_pend_r <= halt_pend_r;
        end
    end
`else
    assign target_pc_s = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_fault = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a redirect takes priority over normal progress.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (req_fire_s) begin
                    state_nxt_s = redirect_valid ? ST_DRAIN : ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt_s = ST_REQ;
                end else if (redirect_valid) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                if (redirect_valid) begin
                    state_nxt_s = (halt_pend_r && !imem_rsp_valid) ? ST_DRAIN : ST_REQ;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
`endif
            default: state_nxt_s = ST_REQ;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign_s) begin
            state_nxt_s = ST_HALT;
        end else begin
            state_nxt_s = state_nxt_s;
        end
`endif
    end

    // FSM outputs and decode port; requests are gated on free FIFO space so a push can never overflow.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_r;
        id_valid       = 1'b0;
        id_instr       = 32'h0000_0000;
        id_pc          = 32'h0000_0000;
        if (!rst && (state_r == ST_REQ) && (count_r < DEPTH_C)) begin
            imem_req_valid = 1'b1;
        end else begin
            imem_req_valid = 1'b0;
        end
        if (count_r != {CNT_W{1'b0}}) begin
            id_valid = ~redirect_valid;
            id_instr = fifo_instr_r[rd_ptr_r];
            id_pc    = fifo_pc_r[rd_ptr_r];
        end else begin
            id_valid = 1'b0;
        end
    end

    // PC and in-flight PC tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_pc_r <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                pc_r <= target_pc_s;
            end else if (req_fire_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (req_fire_s) begin
                inflight_pc_r <= pc_r;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the occupancy-gated head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
            fifo_instr_r[wr_ptr_r] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios push expected requests/decode entries,
// a negedge monitor compares them as the DUT presents handshakes.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_fault;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t req_q[$];
    exp_t dec_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;
    int   mem_lat  = 1;
    int   cyc      = 0;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input int c);
        exp_t e;
        e.pc = a;
        e.cyc = c;
        req_q.push_back(e);
    endtask

    task automatic push_dec(input logic [31:0] a, input int c);
        exp_t e;
        e.pc = a;
        e.cyc = c;
        dec_q.push_back(e);
    endtask

    // Memory model: one response per accepted request, mem_lat cycles after acceptance.
    initial begin
        logic        hs;
        logic        r;
        logic [31:0] a;
        logic        pend;
        int          dly;
        logic [31:0] paddr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        pend  = 1'b0;
        dly   = 0;
        paddr = 32'h0;
        forever begin
            @(negedge clk);
            r  = rst;
            hs = !rst && imem_req_valid && imem_req_ready;
            a  = imem_req_addr;
            if (hs) chk("single_outstanding", {31'd0, pend}, 32'd0);
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (r) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend  = 1'b1;
                    paddr = a;
                    dly   = mem_lat - 1;
                end
                if (pend) begin
                    if (dly == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = instr_of(paddr);
                        pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT shows a request or decode handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (redirect_valid) chk("id_valid_masked", {31'd0, id_valid}, 32'd0);
                if (imem_req_valid && imem_req_ready) begin
                    hs_count++;
                    if (req_q.size() != 0) begin
                        e = req_q.pop_front();
                        chk("req_addr", imem_req_addr, e.pc);
                        if (e.cyc >= 0) chk("req_cycle", cyc, e.cyc);
                    end
                end
                if (id_valid && id_ready) begin
                    if (dec_q.size() != 0) begin
                        e = dec_q.pop_front();
                        chk("id_pc", id_pc, e.pc);
                        chk("id_instr", id_instr, instr_of(e.pc));
                        if (e.cyc >= 0) chk("id_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        req_q.delete();
        dec_q.delete();
    endtask

    task automatic leave_reset(output int c0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0  = cyc;
    endtask

    task automatic wait_hs(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_req_addr == a) found = 1'b1;
        end
        chk("hs_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] a, input logic rdy, output int rc);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = a;
        id_ready       = rdy;
        rc             = cyc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (req_q.size() != 0 || dec_q.size() != 0); i++) begin
            @(negedge clk);
        end
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("dec_q_drained", dec_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0;
        int rc;
        int rc2;
        int h0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        // Streaming: one instruction every two cycles with 1-cycle memory.
        do_reset();
        id_ready = 1'b1;
        mem_lat  = 1;
        leave_reset(c0);
        push_req(32'h0, c0);     push_req(32'h4, c0 + 2); push_req(32'h8, c0 + 4);
        push_dec(32'h0, c0 + 2); push_dec(32'h4, c0 + 4); push_dec(32'h8, c0 + 6);
        wait_drain(60);

        // Back-pressure: FIFO fills after two requests, then fetch resumes at 0x8.
        do_reset();
        mem_lat = 1;
        leave_reset(c0);
        h0 = hs_count;
        push_req(32'h0, c0);
        push_req(32'h4, c0 + 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 4) chk("req_blocked_full", {31'd0, imem_req_valid}, 32'd0);
        end
        chk("req_count_full", hs_count - h0, 32'd2);
        push_req(32'h8, -1);
        push_dec(32'h0, -1); push_dec(32'h4, -1); push_dec(32'h8, -1);
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        wait_drain(60);

        // Redirect coincident with the response for 0x10.
        do_reset();
        id_ready = 1'b1;
        mem_lat  = 1;
        leave_reset(c0);
        push_req(32'h0, -1); push_req(32'h4, -1); push_req(32'h8, -1);
        push_req(32'hC, -1); push_req(32'h10, -1);
        push_dec(32'h0, -1); push_dec(32'h4, -1); push_dec(32'h8, -1);
        push_dec(32'hC, -1); push_dec(32'h100, -1); push_dec(32'h104, -1);
        wait_hs(32'h10);
        pulse_redirect(32'h100, 1'b1, rc);
        push_req(32'h100, rc + 1);
        push_req(32'h104, -1);
        wait_drain(80);

        // Redirect during WAIT with 3-cycle memory: late response is drained.
        do_reset();
        id_ready = 1'b1;
        mem_lat  = 3;
        leave_reset(c0);
        push_req(32'h0, c0);
        wait_hs(32'h0);
        pulse_redirect(32'h200, 1'b1, rc);
        push_req(32'h200, rc + 3);
        push_req(32'h204, rc + 7);
        push_dec(32'h200, rc + 7);
        push_dec(32'h204, -1);
        wait_drain(80);

        // Redirect at the first request (REQ+handshake -> DRAIN) to 0xFFFF_FFFC, then PC wraps to 0.
        do_reset();
        id_ready = 1'b1;
        mem_lat  = 1;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        c0             = cyc;
        push_req(32'h0, c0); push_req(32'hFFFF_FFFC, c0 + 2); push_req(32'h0, c0 + 4);
        push_dec(32'hFFFF_FFFC, c0 + 4); push_dec(32'h0, c0 + 6);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_drain(60);

        // Misaligned redirect while an older entry sits in the FIFO.
        do_reset();
        mem_lat = 1;
        leave_reset(c0);
        push_req(32'h0, c0);
        push_req(32'h4, c0 + 2);
        wait_hs(32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
        pulse_redirect(32'h102, 1'b1, rc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
            chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        pulse_redirect(32'h300, 1'b1, rc2);
        push_req(32'h300, rc2 + 1);
        push_dec(32'h300, rc2 + 3);
        @(negedge clk);
        chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);
`else
        pulse_redirect(32'h102, 1'b1, rc);
        push_req(32'h100, rc + 1);
        push_dec(32'h100, rc + 3);
        push_dec(32'h104, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_fault", {31'd0, fetch_fault}, 32'd0);
        end
        rc2 = rc;
`endif
        wait_drain(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end stage directly upstream of the instruction decoder. Owns the program counter, issues word fetches to instruction memory over a valid/ready request port, buffers returned instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready port. Accepts a redirect (branch/jump/jalr target) from the execute stage that flushes all younger fetch state.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `FIFO_DEPTH`, 2, fetch buffer entries; power of two, 2..8.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word-aligned fetch address (current PC).
- `imem_rsp_valid`  in  1  response data valid; exactly one per accepted request, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  execute stage requests PC change.
- `redirect_pc`  in  32  new PC.
- `id_valid`  out  1  instruction available to decoder.
- `id_ready`  in  1  decoder consumes instruction.
- `id_instr`  out  32  instruction word to decoder.
- `id_pc`  out  32  PC of `id_instr`.
- `fetch_fault`  out  1  misaligned-redirect fault (see Configuration).

## Operation
- Registers: `pc` (32), FSM state, FIFO of {pc, instr} with read/write pointers and occupancy count (width clog2(FIFO_DEPTH)+1).
- At most one outstanding memory request.
- FSM states:
  - REQ: `imem_req_valid` = 1 iff occupancy < FIFO_DEPTH. On handshake: capture issued PC into in-flight register, `pc <= pc + 4` (mod 2^32, wraps 0xFFFF_FFFC → 0), go WAIT.
  - WAIT: `imem_req_valid` = 0. On `imem_rsp_valid`: push {in-flight PC, `imem_rsp_data`}, go REQ.
  - DRAIN: in-flight response is stale. On `imem_rsp_valid`: discard, go REQ.
  - HALT: only with FETCH_MISALIGN_TRAP_EN; no requests.
- Space reservation: a request is issued only when occupancy < FIFO_DEPTH, so the push in WAIT never overflows.
- Decode port: `id_valid` = FIFO non-empty AND NOT `redirect_valid`; `id_instr`/`id_pc` = FIFO head. Pop on `id_valid & id_ready`.
- Simultaneous push and pop: occupancy unchanged; legal when full only because space was reserved.
- Redirect (`redirect_valid` = 1), highest priority, at the clock edge:
  - FIFO flushed (pointers and count to 0); any pop that cycle is suppressed (`id_valid` already masked).
  - `pc <= redirect_pc`.
  - From REQ without handshake: stay REQ. From REQ with handshake same cycle: go DRAIN.
  - From WAIT without `imem_rsp_valid`: go DRAIN. From WAIT with `imem_rsp_valid`: response discarded, go REQ.
  - From DRAIN with `imem_rsp_valid`: discard, go REQ. From DRAIN without: stay DRAIN.
- Reset mid-operation: all state cleared regardless of in-flight request. An outstanding response arriving after reset is not tracked; memory must be reset with the same `rst`.

## Timing
- Reset values: `pc` = RESET_PC, state REQ, FIFO empty, `imem_req_valid` = 0 while `rst` = 1, `imem_req_addr` = RESET_PC, `id_valid` = 0, `id_instr`/`id_pc` = 0, `fetch_fault` = 0.
- First request: cycle after `rst` deasserts, address RESET_PC.
- Response to decode latency: `id_valid` rises the cycle after the `imem_rsp_valid` cycle (registered FIFO, no bypass).
- Peak throughput: 1 instruction per 2 cycles with 1-cycle memory.
- Redirect to new request: `imem_req_valid` with `redirect_pc` the cycle after redirect from REQ or WAIT+rsp; after drain response otherwise.
- All outputs are combinational from registered state except the `id_valid` mask and `imem_req_valid` (from `rst` and occupancy).

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: a redirect with `redirect_pc[1:0]` != 0 sets `fetch_fault` = 1 (sticky), flushes the FIFO, and enters HALT. Any in-flight response is discarded. HALT is left only by reset or by an aligned redirect, which clears `fetch_fault` and behaves as from REQ.
- Not defined: `redirect_pc[1:0]` is forced to 0, `fetch_fault` is tied 0, and the HALT state is absent.

## Test plan
- Reset, memory ready always, 1-cycle response, `id_ready` = 1 → requests at 0x0, 0x4, 0x8. `id_pc` sequence 0x0, 0x4, 0x8 with matching `id_instr`, one every 2 cycles.
- `id_ready` = 0, FIFO_DEPTH = 2 → exactly two requests are issued. `imem_req_valid` stays 0 while full. Raise `id_ready` → fetch resumes at 0x8.
- Redirect to 0x100 in the same cycle as `imem_rsp_valid` (instr at 0x10) → 0x10 never appears on decode. Next request address is 0x100.
- Redirect to 0x200 during WAIT with 3-cycle memory latency → late response discarded (DRAIN). `id_pc` next = 0x200. No FIFO entry from the old path.
- PC at 0xFFFF_FFFC → following request address is 0x0000_0000.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x102 → `fetch_fault` = 1, no requests. Then redirect to 0x300 → `fetch_fault` = 0, request at 0x300. Without the macro: fetch proceeds at 0x100 and `fetch_fault` stays 0.
